// File: rtl/mic_pkg.sv
// Shared types and sizing for the mic frame requester slice.
package mic_pkg;

  localparam int N_SAMPLES = 16;
  localparam int SAMPLE_W  = 18;
  localparam int IDX_W     = $clog2(N_SAMPLES);

  typedef logic signed [SAMPLE_W-1:0]  sample_t;
  typedef logic [IDX_W-1:0]            idx_t;
  typedef logic [N_SAMPLES*SAMPLE_W-1:0] frame_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    STREAM
  } req_state_t;

  function automatic logic is_last(input idx_t i);
    return i == idx_t'(N_SAMPLES - 1);
  endfunction

endpackage

// File: rtl/mic_frame_requester_if.sv
// Sampler handshake plus downstream valid/ready stream bundle.
interface mic_frame_requester_if;
  import mic_pkg::*;

  logic    start;
  logic    done;
  frame_t  samples_in;
  logic    out_valid;
  logic    out_ready;
  sample_t out_data;
  idx_t    out_index;
  logic    out_last;

  modport master (
    output start,
    input  done,
    input  samples_in,
    output out_valid,
    input  out_ready,
    output out_data,
    output out_index,
    output out_last
  );

  modport slave (
    input  start,
    output done,
    output samples_in,
    input  out_valid,
    output out_ready,
    input  out_data,
    input  out_index,
    input  out_last
  );

endinterface

// File: rtl/mic_frame_buffer.sv
// Frame store: whole frame loads in one cycle, one sample read per index.
module mic_frame_buffer
  import mic_pkg::*;
(
  input  logic    clk_i,
  input  logic    load_i,
  input  frame_t  samples_i,
  input  idx_t    rd_idx_i,
  output sample_t rd_data_o
);

  sample_t buf_q [N_SAMPLES];

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      for (int k = 0; k < N_SAMPLES; k++) begin
        buf_q[k] <= samples_i[k*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  assign rd_data_o = buf_q[rd_idx_i];

endmodule

// File: rtl/mic_frame_requester.sv
// Requests mic frames, latches them, streams one sample per beat.
// Optional WAIT timeout/retry: define MIC_REQ_TIMEOUT_EN.
module mic_frame_requester
  import mic_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4096
)
(
  input  logic                  clk_25,
  input  logic                  rst,
  input  logic                  enable,
  mic_frame_requester_if.master bus,
  output logic [15:0]           frame_count,
  output logic                  timeout_err
);

  req_state_t  state_q, state_d;
  idx_t        idx_q, idx_d;
  logic        armed_q, armed_d;
  logic [15:0] fcnt_q, fcnt_d;
  logic        load;
  logic        beat;
  sample_t     rd_data;

`ifdef MIC_REQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC);

  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             terr_q, terr_d;
  logic             expired;

  assign expired = tmr_q == TMR_W'(TIMEOUT_CYC - 1);
`endif

  mic_frame_buffer u_buf (
    .clk_i     (clk_25),
    .load_i    (load),
    .samples_i (bus.samples_in),
    .rd_idx_i  (idx_q),
    .rd_data_o (rd_data)
  );

  assign bus.start     = state_q == REQ;
  assign bus.out_valid = state_q == STREAM;
  assign bus.out_index = idx_q;
  assign bus.out_last  = bus.out_valid && is_last(idx_q);
  assign bus.out_data  = bus.out_valid ? rd_data : '0;
  assign beat          = bus.out_valid && bus.out_ready;
  assign frame_count   = fcnt_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    armed_d = armed_q;
    fcnt_d  = fcnt_q;
    load    = 1'b0;
`ifdef MIC_REQ_TIMEOUT_EN
    tmr_d   = '0;
    terr_d  = terr_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (enable) state_d = REQ;
      end
      REQ: begin
        armed_d = 1'b0;
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.done && armed_q) begin
          load    = 1'b1;
          state_d = STREAM;
        end else begin
          if (!bus.done) armed_d = 1'b1;
`ifdef MIC_REQ_TIMEOUT_EN
          tmr_d = tmr_q + 1'b1;
          if (expired) begin
            terr_d  = 1'b1;
            state_d = REQ;
          end
`endif
        end
      end
      STREAM: begin
        if (beat) begin
          if (is_last(idx_q)) begin
            idx_d   = '0;
            fcnt_d  = fcnt_q + 16'd1;
            state_d = IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      armed_q <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      armed_q <= armed_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef MIC_REQ_TIMEOUT_EN
  always_ff @(posedge clk_25) begin
    if (rst) begin
      tmr_q  <= '0;
      terr_q <= 1'b0;
    end else begin
      tmr_q  <= tmr_d;
      terr_q <= terr_d;
    end
  end

  assign timeout_err = terr_q;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_mic_frame_requester.sv
// Directed bench for mic_frame_requester.
module tb_mic_frame_requester;
  import mic_pkg::*;

  localparam int TO = 64;

  logic        clk_25 = 1'b0;
  logic        rst    = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] frame_count;
  logic        timeout_err;

  mic_frame_requester_if bus ();

  mic_frame_requester #(.TIMEOUT_CYC(TO)) dut (
    .clk_25      (clk_25),
    .rst         (rst),
    .enable      (enable),
    .bus         (bus),
    .frame_count (frame_count),
    .timeout_err (timeout_err)
  );

  always #20 clk_25 = ~clk_25;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  int      starts = 0;
  int      cyc    = 0;
  int      st_prev = 0;
  int      st_last = 0;
  int      q_d[$];
  int      q_i[$];
  int      q_l[$];
  logic    stall_pend = 1'b0;
  sample_t s_dat;
  idx_t    s_idx;

  always @(negedge clk_25) begin
    cyc++;
    if (bus.start) begin
      starts++;
      st_prev = st_last;
      st_last = cyc;
    end
    if (stall_pend && bus.out_valid) begin
      chk("stall_data", bus.out_data, s_dat);
      chk("stall_idx", bus.out_index, s_idx);
    end
    if (bus.out_valid && bus.out_ready) begin
      q_d.push_back(int'(bus.out_data));
      q_i.push_back(int'(bus.out_index));
      q_l.push_back(int'(bus.out_last));
    end
    stall_pend = bus.out_valid && !bus.out_ready;
    s_dat      = bus.out_data;
    s_idx      = bus.out_index;
  end

  task automatic tick();
    @(posedge clk_25);
    #1;
  endtask

  task automatic set_samples(input int mul, input int off);
    for (int k = 0; k < N_SAMPLES; k++) begin
      bus.samples_in[k*SAMPLE_W +: SAMPLE_W] = SAMPLE_W'(k * mul + off);
    end
  endtask

  task automatic clr_q();
    q_d.delete();
    q_i.delete();
    q_l.delete();
  endtask

  task automatic check_frame(input string tag, input int mul, input int off);
    chk({tag, "_beats"}, q_d.size(), N_SAMPLES);
    for (int k = 0; k < N_SAMPLES && k < q_d.size(); k++) begin
      chk($sformatf("%s_d%0d", tag, k), q_d[k], k * mul + off);
      chk($sformatf("%s_i%0d", tag, k), q_i[k], k);
      chk($sformatf("%s_l%0d", tag, k), q_l[k], (k == N_SAMPLES - 1) ? 1 : 0);
    end
    clr_q();
  endtask

  task automatic wait_fc(input string tag, input int n);
    for (int i = 0; i < 300; i++) begin
      if (frame_count == 16'(n)) break;
      tick();
    end
    chk(tag, frame_count, n);
  endtask

  task automatic wait_beats(input string tag, input int n);
    for (int i = 0; i < 300; i++) begin
      if (q_d.size() >= n) break;
      tick();
    end
    chk(tag, q_d.size(), n);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  int s0;

  initial begin
    bus.done      = 1'b0;
    bus.out_ready = 1'b1;
    set_samples(0, 0);
    repeat (3) tick();

    chk("rst_start", bus.start, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_index", bus.out_index, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_fc", frame_count, 0);
    chk("rst_terr", timeout_err, 0);

    rst = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    chk("t1_start", bus.start, 1);
    repeat (20) tick();
    chk("t1_start_once", bus.start, 0);
    bus.done = 1'b1;
    set_samples(1000, 0);
    chk("t1_noearly", bus.out_valid, 0);
    tick();
    chk("t1_vrise", bus.out_valid, 1);
    wait_fc("t1_fc", 1);
    check_frame("t1", 1000, 0);
    chk("t1_starts", starts, 1);

    set_samples(3, 7);
    repeat (10) tick();
    chk("t2_req", starts, 2);
    chk("t2_nobeats", q_d.size(), 0);
    chk("t2_novalid", bus.out_valid, 0);
    bus.done = 1'b0;
    repeat (3) tick();
    chk("t2_still_idle", bus.out_valid, 0);
    bus.done = 1'b1;
    set_samples(-500, 123);
    bus.out_ready = 1'b0;
    tick();
    set_samples(3, 7);

    for (int i = 0; i < 200; i++) begin
      if (frame_count == 16'd2) break;
      bus.out_ready = ~bus.out_ready;
      tick();
    end
    chk("t3_fc", frame_count, 2);
    check_frame("t3", -500, 123);
    bus.out_ready = 1'b1;

    repeat (4) tick();
    bus.done = 1'b0;
    repeat (2) tick();
    bus.done = 1'b1;
    set_samples(1000, -8000);
    tick();
    set_samples(3, 7);
    wait_beats("t4_b5", 5);
    enable = 1'b0;
    wait_fc("t4_fc", 3);
    check_frame("t4", 1000, -8000);
    repeat (40) tick();
    chk("t4_nostart", starts, 3);
    chk("t4_idle", bus.out_valid, 0);

    enable = 1'b1;
    repeat (4) tick();
    bus.done = 1'b0;
    repeat (2) tick();
    bus.done = 1'b1;
    set_samples(1000, 0);
    tick();
    wait_beats("t5_b8", 8);
    rst = 1'b1;
    tick();
    chk("t5_valid", bus.out_valid, 0);
    chk("t5_fc", frame_count, 0);
    chk("t5_index", bus.out_index, 0);
    chk("t5_last", bus.out_last, 0);
    chk("t5_data", bus.out_data, 0);
    clr_q();
    rst = 1'b0;
    tick();
    chk("t5_fresh", bus.start, 1);
    repeat (2) tick();
    bus.done = 1'b0;
    repeat (2) tick();
    bus.done = 1'b1;
    set_samples(-1000, 7000);
    wait_fc("t5_fc1", 1);
    check_frame("t5", -1000, 7000);

    bus.done = 1'b0;
    s0 = starts;
`ifdef MIC_REQ_TIMEOUT_EN
    repeat (30) tick();
    chk("t6_pre", timeout_err, 0);
    repeat (150) tick();
    chk("t6_retry", (starts - s0 >= 3) ? 1 : 0, 1);
    chk("t6_gap", st_last - st_prev, TO + 1);
    chk("t6_terr", timeout_err, 1);
    enable = 1'b0;
    repeat (80) tick();
    chk("t6_sticky", timeout_err, 1);
`else
    repeat (300) tick();
    chk("t6_onestart", starts - s0, 1);
    chk("t6_terr", timeout_err, 0);
    chk("t6_novalid", bus.out_valid, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
